// File: rtl/ntt_pkg.sv
// Shared constants and modular add/sub helpers for the NTT datapath.
// The modulus and width here must match the ones built into modular_multiplier.
package ntt_pkg;

  localparam int unsigned DATA_W  = 32'd30;
  localparam logic [DATA_W-1:0] NTT_Q = 30'd998244353;
  localparam int unsigned MUL_LAT = 32'd1;

  typedef logic [DATA_W-1:0] coef_t;
  typedef logic [DATA_W:0]   coef_ext_t;

  // (x + y) mod Q for x, y < Q; one extra bit holds the carry before folding.
  function automatic coef_t mod_add(input coef_t x, input coef_t y);
    coef_ext_t s;
    coef_ext_t q_ext;
    coef_t     r;
    q_ext = {1'b0, NTT_Q};
    s     = {1'b0, x} + {1'b0, y};
    if (s >= q_ext) begin
      s = s - q_ext;
    end else begin
      s = s;
    end
    r = s[DATA_W-1:0];
    return r;
  endfunction

  // (x - y) mod Q for x, y < Q; a negative raw difference is lifted by Q.
  function automatic coef_t mod_sub(input coef_t x, input coef_t y);
    coef_ext_t d;
    coef_ext_t q_ext;
    coef_t     r;
    q_ext = {1'b0, NTT_Q};
    d     = {1'b0, x} - {1'b0, y};
    if (x >= y) begin
      d = d;
    end else begin
      d = d + q_ext;
    end
    r = d[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/modular_multiplier.sv
// Pipelined modular multiplier: c = (a * b) mod Q, MUL_LAT register stages.
module modular_multiplier #(
  parameter int unsigned       DATA_W  = ntt_pkg::DATA_W,
  parameter logic [DATA_W-1:0] Q       = ntt_pkg::NTT_Q,
  parameter int unsigned       MUL_LAT = ntt_pkg::MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c
);
  import ntt_pkg::*;

  localparam logic [2*DATA_W-1:0] Q_WIDE = {{DATA_W{1'b0}}, Q};

  logic [2*DATA_W-1:0]             prod_s;
  logic [DATA_W-1:0]               rem_s;
  logic [MUL_LAT-1:0][DATA_W-1:0]  pipe_r;

  // Full-width product reduced by the modulus.
  always_comb begin
    prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    rem_s  = DATA_W'(prod_s % Q_WIDE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        // First stage captures the reduced product.
        always_ff @(posedge clk) begin
          if (rst) pipe_r[gi] <= '0;
          else     pipe_r[gi] <= rem_s;
        end
      end else begin : g_next
        // Later stages only add latency.
        always_ff @(posedge clk) begin
          if (rst) pipe_r[gi] <= '0;
          else     pipe_r[gi] <= pipe_r[gi-1];
        end
      end
    end
  endgenerate

  assign c = pipe_r[MUL_LAT-1];

endmodule

// File: rtl/ntt_butterfly_mod_add_sub.sv
// Combinational modular sum/difference pair; registered by the caller.
module mod_add_sub
  import ntt_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] diff
);

  // Both results come from the shared package helpers.
  always_comb begin
    sum  = mod_add(x, y);
    diff = mod_sub(x, y);
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Streaming radix-2 NTT butterfly, one butterfly per clock, latency MUL_LAT+1.
// Default: Cooley-Tukey  x = a + w*b, y = a - w*b (mod Q).
// With NTT_BUTTERFLY_GS_EN defined: Gentleman-Sande  x = a + b, y = (a - b)*w (mod Q).
module ntt_butterfly #(
  parameter int unsigned       DATA_W  = ntt_pkg::DATA_W,
  parameter logic [DATA_W-1:0] Q       = ntt_pkg::NTT_Q,
  parameter int unsigned       MUL_LAT = ntt_pkg::MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] w,
  output logic              out_valid,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);
  import ntt_pkg::*;

  localparam int unsigned L = MUL_LAT + 32'd1;

  logic [L-1:0]                    valid_pipe_r;
  logic [MUL_LAT-1:0][DATA_W-1:0]  dly_r;
  logic [DATA_W-1:0]               dly_in_s;
  logic [DATA_W-1:0]               dly_out_s;
  logic [DATA_W-1:0]               prod_s;
  logic [DATA_W-1:0]               sum_s;
  logic [DATA_W-1:0]               diff_s;

  // Valid tracks data through all L stages; gaps pass straight through.
  always_ff @(posedge clk) begin
    if (rst) valid_pipe_r <= '0;
    else     valid_pipe_r <= {valid_pipe_r[L-2:0], in_valid};
  end

  assign out_valid = valid_pipe_r[L-1];

  // Delay line runs alongside the multiplier so its output lines up with prod_s.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        // Head of the delay line.
        always_ff @(posedge clk) begin
          if (rst) dly_r[gi] <= '0;
          else     dly_r[gi] <= dly_in_s;
        end
      end else begin : g_next
        // Remaining taps of the delay line.
        always_ff @(posedge clk) begin
          if (rst) dly_r[gi] <= '0;
          else     dly_r[gi] <= dly_r[gi-1];
        end
      end
    end
  endgenerate

  assign dly_out_s = dly_r[MUL_LAT-1];

`ifdef NTT_BUTTERFLY_GS_EN
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] w_r;

  mod_add_sub u_as (.x(a), .y(b), .sum(sum_s), .diff(diff_s));

  // Add/sub stage first; w is held one cycle to meet d at the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r <= '0;
      d_r <= '0;
      w_r <= '0;
    end else begin
      s_r <= sum_s;
      d_r <= diff_s;
      w_r <= w;
    end
  end

  modular_multiplier #(.DATA_W(DATA_W), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst(rst), .a(w_r), .b(d_r), .c(prod_s)
  );

  assign dly_in_s = s_r;
  assign x        = dly_out_s;
  assign y        = prod_s;
`else
  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] y_r;

  modular_multiplier #(.DATA_W(DATA_W), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst(rst), .a(w), .b(b), .c(prod_s)
  );

  assign dly_in_s = a;

  mod_add_sub u_as (.x(dly_out_s), .y(prod_s), .sum(sum_s), .diff(diff_s));

  // Register the sum/difference of the delayed a against w*b.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
    end else begin
      x_r <= sum_s;
      y_r <= diff_s;
    end
  end

  assign x = x_r;
  assign y = y_r;
`endif

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: vector table, hand sequences, random
// stream, all scored through a due-cycle queue. Honors NTT_BUTTERFLY_GS_EN.
module tb_ntt_butterfly;

  localparam int unsigned    DW   = 30;
  localparam int unsigned    LAT  = 2;
  localparam longint unsigned QM = 64'd998244353;

  typedef struct {
    logic [DW-1:0] a, b, w, ex, ey;
  } vec_t;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] ex, ey;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a = '0, b = '0, w = '0;
  logic          out_valid;
  logic [DW-1:0] x, y;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic        rst_q    = 1'b0;
  exp_t        exp_q[$];
  vec_t        vecs[6];

  ntt_butterfly dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .w(w),
    .out_valid(out_valid), .x(x), .y(y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Independent 64-bit reference model.
  function automatic void model(input logic [DW-1:0] aa, bb, ww,
                                output logic [DW-1:0] ex, ey);
    longint unsigned la, lb, lw, t, d;
    la = 64'(aa); lb = 64'(bb); lw = 64'(ww);
`ifdef NTT_BUTTERFLY_GS_EN
    d  = (la + QM - lb) % QM;
    ex = DW'((la + lb) % QM);
    ey = DW'((d * lw) % QM);
`else
    t  = (lw * lb) % QM;
    ex = DW'((la + t) % QM);
    ey = DW'((la + QM - t) % QM);
`endif
  endfunction

  // Output monitor: every cycle is either a reset, an expected beat, or idle.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_q) begin
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        check("x", 32'(x), 32'(e.ex));
        check("y", 32'(y), 32'(e.ey));
      end else begin
        check("idle_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic drive_exp(input logic v, input logic [DW-1:0] aa, bb, ww, ex, ey, input logic r);
    exp_t e;
    rst = r; in_valid = v; a = aa; b = bb; w = ww;
    if (r) begin
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
    end else if (v) begin
      e.due = cyc + LAT; e.ex = ex; e.ey = ey;
      exp_q.push_back(e);
    end else begin
      e.due = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] aa, bb, ww, input logic r);
    logic [DW-1:0] ex, ey;
    model(aa, bb, ww, ex, ey);
    drive_exp(v, aa, bb, ww, ex, ey, r);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] qm1;
    qm1 = 30'd998244352;
`ifdef NTT_BUTTERFLY_GS_EN
    vecs[0] = '{30'd10, 30'd3,  30'd2,  30'd13,  30'd14};
    vecs[1] = '{30'd3,  30'd10, 30'd2,  30'd13,  30'd998244339};
    vecs[2] = '{qm1,    30'd1,  30'd1,  30'd0,   30'd998244351};
    vecs[3] = '{30'd0,  30'd1,  30'd1,  30'd1,   30'd998244352};
    vecs[4] = '{30'd5,  30'd5,  30'd1,  30'd10,  30'd0};
    vecs[5] = '{30'd0,  qm1,    30'd1,  qm1,     30'd1};
`else
    vecs[0] = '{30'd10, 30'd10, 30'd10, 30'd110, 30'd998244263};
    vecs[1] = '{qm1,    30'd1,  30'd1,  30'd0,   30'd998244351};
    vecs[2] = '{30'd0,  30'd1,  30'd1,  30'd1,   30'd998244352};
    vecs[3] = '{30'd5,  30'd5,  30'd1,  30'd10,  30'd0};
    vecs[4] = '{30'd0,  qm1,    30'd1,  qm1,     30'd1};
    vecs[5] = '{30'd10, 30'd3,  30'd2,  30'd16,  30'd4};
`endif

    // Reset with in_valid high: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; a = 30'd7; b = 30'd7; w = 30'd7;
    repeat (3) @(posedge clk);
    #1;
    idle(2);

    // Table vectors as isolated single pulses.
    for (int i = 0; i < 6; i++) begin
      drive_exp(1'b1, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].ex, vecs[i].ey, 1'b0);
      idle(LAT + 1);
    end

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(i), DW'(i + 1), 30'd2, 1'b0);
    idle(LAT + 1);

    // Valid gap propagates.
    drive(1'b1, 30'd11, 30'd12, 30'd13, 1'b0);
    drive(1'b0, 30'd99, 30'd99, 30'd99, 1'b0);
    drive(1'b1, 30'd21, 30'd22, 30'd23, 1'b0);
    idle(LAT + 1);

    // Reset mid-stream, then an item right after release.
    drive(1'b1, 30'd100, 30'd200, 30'd300, 1'b0);
    drive(1'b1, 30'd400, 30'd500, 30'd600, 1'b0);
    drive(1'b1, 30'd1,   30'd2,   30'd3,   1'b1);
    drive(1'b1, 30'd77,  30'd88,  30'd99,  1'b0);
    idle(LAT + 2);

    // Random stream with random valid gaps.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0,
            DW'($urandom_range(32'd998244352, 32'd0)),
            DW'($urandom_range(32'd998244352, 32'd0)),
            DW'($urandom_range(32'd998244352, 32'd0)), 1'b0);
    end
    idle(LAT + 3);

    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
